// File: rtl/scfifo_pack_reader_pkg.sv
// Shared types for the FIFO pack reader: flush FSM encoding and count-width helper.
package scfifo_pack_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } flush_state_e;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/scfifo_pack_reader.sv
// Reads DW-bit words from a 1-cycle-latency FIFO and packs RATIO of them per output beat.
// First beat RATIO+1 cycles after first read; m_ready low holds the beat and stalls reads once packed full.
module scfifo_pack_reader
  import scfifo_pack_pkg::*;
#(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = cnt_width(RATIO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  output logic                fifo_read,
  input  logic [DW-1:0]       fifo_dout,
  input  logic                flush,
  output logic                flush_done,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW*RATIO-1:0] m_data,
  output logic [CW-1:0]       m_cnt,
  output logic                m_last
);

  logic [DW*RATIO-1:0] pack, pack_merged, pack_partial;
  logic [CW-1:0]       wc, fill;
  logic                pend;
  flush_state_e        state;
  logic                flushing, out_free, full, xfer, emit;

  // fill counts the word landing this cycle, so a beat can leave with it merged in.
  assign fill      = wc + CW'(pend);
  assign full      = (fill == CW'(RATIO));
  assign out_free  = !m_valid || m_ready;
  assign xfer      = full && out_free;
  assign flushing  = (state != IDLE);
  assign emit      = (state == FLUSH_EMIT) && out_free;
  assign fifo_read = !rst && !fifo_empty && !flushing && ((fill < CW'(RATIO)) || xfer);

  always_comb begin
    pack_merged  = pack;
    pack_partial = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (pend && (wc == CW'(i))) pack_merged[i*DW +: DW] = fifo_dout;
      if (CW'(i) < wc)            pack_partial[i*DW +: DW] = pack[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack       <= '0;
      wc         <= '0;
      pend       <= 1'b0;
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_cnt      <= '0;
      m_last     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      pack       <= pack_merged;
      pend       <= fifo_read;

      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= pack_partial;
        m_cnt   <= wc;
        m_last  <= 1'b1;
      end else if (xfer) begin
        m_valid <= 1'b1;
        m_data  <= pack_merged;
        m_cnt   <= CW'(RATIO);
        m_last  <= flushing;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (emit || xfer) wc <= '0;
      else if (pend)    wc <= wc + CW'(1);

      // A full beat leaving mid-flush empties the packer, so it also closes the flush.
      case (state)
        IDLE: if (flush) state <= FLUSH_WAIT;
        FLUSH_WAIT: begin
          if (xfer || (!pend && wc == '0)) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end else if (!pend) begin
            state <= FLUSH_EMIT;
          end
        end
        FLUSH_EMIT: begin
          if (emit) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scfifo_pack_reader.sv
// Directed bench for scfifo_pack_reader with a behavioural 1-cycle-latency FIFO and beat scoreboard.
module tb_scfifo_pack_reader;

  logic        clk = 1'b0;
  logic        rst, fifo_empty, fifo_read, flush, flush_done;
  logic        m_valid, m_ready, m_last;
  logic [7:0]  fifo_dout = 8'h00;
  logic [31:0] m_data;
  logic [2:0]  m_cnt;

  always #5 clk = ~clk;

  scfifo_pack_reader #(.DW(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_dout(fifo_dout), .flush(flush), .flush_done(flush_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_cnt(m_cnt), .m_last(m_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, empty derived from pointers
  logic [7:0] mem [0:63];
  int         wp = 0;
  int         rp = 0;
  logic       force_ne = 1'b0;

  assign fifo_empty = force_ne ? 1'b0 : (wp == rp);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_dout <= mem[rp[5:0]];
      rp        <= rp + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 1;
  endtask

  // Monitor / scoreboard
  logic        mon_clr = 1'b0;
  int          cyc = 0;
  int          rd_count, run, max_run, first_rd, first_v, nb, fd_n, fd_cyc, fl_cyc, rd_at_fd;
  logic [31:0] bd [0:15];
  logic [2:0]  bc [0:15];
  logic        bl [0:15];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      rd_count <= 0; run <= 0; max_run <= 0; first_rd <= -1; first_v <= -1;
      nb <= 0; fd_n <= 0; fd_cyc <= -1; fl_cyc <= -1; rd_at_fd <= -1;
    end else begin
      if (fifo_read) begin
        rd_count <= rd_count + 1;
        run      <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
        if (first_rd < 0) first_rd <= cyc;
      end else begin
        run <= 0;
      end
      if (m_valid && first_v < 0) first_v <= cyc;
      if (m_valid && m_ready && nb < 16) begin
        bd[nb] <= m_data;
        bc[nb] <= m_cnt;
        bl[nb] <= m_last;
        nb     <= nb + 1;
      end
      if (flush_done) begin
        fd_n <= fd_n + 1;
        if (fd_n == 0) begin
          fd_cyc   <= cyc;
          rd_at_fd <= rd_count;
        end
      end
      if (flush) fl_cyc <= cyc;
    end
  end

  task automatic clr();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (nb < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, nb, n);
  endtask

  initial begin
    rst = 1'b1; force_ne = 1'b1; m_ready = 1'b0; flush = 1'b0; mon_clr = 1'b1;

    // 1: reset holds off reads; outputs cleared
    @(negedge clk); check("rst_read_a", fifo_read, 0);
    @(negedge clk); check("rst_read_b", fifo_read, 0);
    rst = 1'b0; force_ne = 1'b0; mon_clr = 1'b0;
    @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_data",  m_data, 0);
    check("rst_cnt",   m_cnt, 0);
    check("rst_last",  m_last, 0);
    check("rst_fdone", flush_done, 0);

    // 2: streaming two full beats
    clr();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    wait_beats(2, 40, "t2_nbeats");
    check("t2_data0", bd[0], 32'h44332211);
    check("t2_cnt0",  bc[0], 4);
    check("t2_last0", bl[0], 0);
    check("t2_data1", bd[1], 32'h88776655);
    check("t2_cnt1",  bc[1], 4);
    check("t2_last1", bl[1], 0);
    check("t2_reads", rd_count, 8);
    check("t2_run",   max_run, 8);
    check("t2_lat",   first_v - first_rd, 5);

    // 3: backpressure
    clr();
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    repeat (12) @(negedge clk);
    check("t3_valid", m_valid, 1);
    check("t3_data_a", m_data, 32'h04030201);
    repeat (10) @(negedge clk);
    check("t3_data_b", m_data, 32'h04030201);
    check("t3_cnt",    m_cnt, 4);
    check("t3_last",   m_last, 0);
    check("t3_reads_stall", rd_count, 8);
    m_ready = 1'b1;
    wait_beats(3, 30, "t3_nbeats");
    check("t3_b0", bd[0], 32'h04030201);
    check("t3_b1", bd[1], 32'h08070605);
    check("t3_b2", bd[2], 32'h0C0B0A09);
    check("t3_reads", rd_count, 12);

    // 4: partial flush
    clr();
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_beats(1, 20, "t4_nbeats");
    repeat (3) @(negedge clk);
    check("t4_data", bd[0], 32'h00A3A2A1);
    check("t4_cnt",  bc[0], 3);
    check("t4_last", bl[0], 1);
    check("t4_fdone_n", fd_n, 1);
    check("t4_fdone_cyc", fd_cyc, first_v);

    // 5: flush while a read is in flight; leftover word joins the next beat
    clr();
    push(8'hB1); push(8'hB2); push(8'hB3);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_beats(1, 20, "t5_nbeats");
    repeat (3) @(negedge clk);
    check("t5_data", bd[0], 32'h0000B2B1);
    check("t5_cnt",  bc[0], 2);
    check("t5_last", bl[0], 1);
    check("t5_fdone_n", fd_n, 1);
    check("t5_reads_flush", rd_at_fd, 2);
    push(8'hB4); push(8'hB5); push(8'hB6);
    wait_beats(2, 30, "t5_nbeats2");
    check("t5_data2", bd[1], 32'hB6B5B4B3);
    check("t5_last2", bl[1], 0);

    // 6a: flush with nothing buffered
    clr();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_fdone_n", fd_n, 1);
    check("t6_fdone_dly", fd_cyc - fl_cyc, 2);
    check("t6_nobeat", nb, 0);

    // 6b: reset mid-pack discards landed and in-flight words
    clr();
    push(8'hD1); push(8'hD2); push(8'hD3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(8'hC0 + i));
    wait_beats(1, 20, "t6_nbeats");
    check("t6_data", bd[0], 32'hC4C3C2C1);
    check("t6_cnt",  bc[0], 4);
    check("t6_last", bl[0], 0);
    check("t6_reads", rd_count, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scfifo_pack_reader.md
Name: scfifo_pack_reader

Overview:
- Downstream consumer of the single-clock FIFO (DW/AW family).
- Drives the FIFO read strobe against its empty flag and absorbs the FIFO's registered 1-cycle read latency.
- Packs RATIO consecutive DW-bit words into one wide beat and presents it on a valid/ready master stream.
- A flush request emits a trailing partial beat, so packet tails are not stranded in the packer.

Parameters:
- DW, 8, FIFO word width in bits.
- RATIO, 4, words per output beat; legal range ≥2.
- CW, $clog2(RATIO+1), derived width of word counts; not overridden.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset: synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  FIFO read strobe. fifo_dout is valid on the cycle after a cycle with fifo_read high.
- fifo_dout  in  DW  FIFO read data.
- flush  in  1  single-cycle request to emit buffered words.
- flush_done  out  1  single-cycle pulse marking completion of a flush.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DW*RATIO  packed beat; the first-read word is at bits [DW-1:0].
- m_cnt  out  CW  valid words in the beat, 1..RATIO.
- m_last  out  1  beat closes a flush.

Behaviour:
- Reset: rst sampled at posedge clears all state. While rst is high, fifo_read is 0.
  - After reset: m_valid=0, m_data=0, m_cnt=0, m_last=0, flush_done=0.
  - Internal state after reset: wc=0, pend=0, flush state idle.
- Reset mid-operation: a word already requested from the FIFO is discarded, because pend is cleared.
- State:
  - pack register holds RATIO words.
  - wc (0..RATIO) counts words held in the pack register.
  - pend is high on the cycle fifo_dout is due.
  - An output register holds the m_* signals.
  - Invariant: wc + pend ≤ RATIO.
- Landing: when pend=1, fifo_dout is written into slot wc.
- out_free = !m_valid || m_ready.
- Transfer (xfer): fires when (wc + pend == RATIO) and out_free.
  - m_data takes the pack contents, including a landing word merged in that same cycle.
  - m_cnt=RATIO, m_valid=1.
  - Then wc=0.
- Read issue: fifo_read = !rst && !fifo_empty && !flushing && ((wc + pend < RATIO) || xfer).
  - This sustains 1 word/cycle with no bubbles while m_ready=1.
- Latency: the first m_valid comes exactly RATIO+1 cycles after the first fifo_read, when the FIFO is never empty.
- Backpressure:
  - m_valid=1 with m_ready=0 holds m_data, m_cnt and m_last stable.
  - The pack register fills to wc=RATIO, then fifo_read deasserts.
  - No word is lost or duplicated.
- Flush FSM: states IDLE, FLUSH_WAIT, FLUSH_EMIT.
  - IDLE, flush=1: go to FLUSH_WAIT. flushing is high in FLUSH_WAIT and FLUSH_EMIT.
  - flush while not IDLE is ignored.
  - FLUSH_WAIT: no new reads are issued; the block waits until pend=0. Then:
    - if wc=0, pulse flush_done and go to IDLE;
    - otherwise go to FLUSH_EMIT.
  - FLUSH_EMIT, when out_free: load the partial beat, then pulse flush_done and go to IDLE.
    - Partial beat: m_cnt=wc, m_last=1, unused upper slots zero.
  - If a full-RATIO xfer happens while flushing and leaves wc=0, that beat carries m_last=1. flush_done pulses in the same cycle as its load.
- m_last=0 on all non-flush beats.
- Width rules:
  - wc and m_cnt are unsigned CW bits.
  - Slot index wc is always < RATIO when a word lands.

Decomposition:
- Package scfifo_pack_pkg holds:
  - typedef enum logic [1:0] flush_state_e {IDLE, FLUSH_WAIT, FLUSH_EMIT};
  - function cnt_width(ratio).
- No sub-module. The output register is inline; splitting it out gains nothing at this size.

Test Plan:
1. Reset: hold rst 2 cycles with fifo_empty=0 -> fifo_read=0 throughout; every output is 0 on the first cycle after rst falls.
2. Streaming, DW=8/RATIO=4: FIFO holds 0x11..0x88, m_ready=1.
   - fifo_read is high for 8 consecutive cycles.
   - Beats 0x44332211 then 0x88776655, each with m_cnt=4 and m_last=0.
   - First m_valid exactly 5 cycles after the first fifo_read.
3. Backpressure: 12 words queued, m_ready=0.
   - First beat held stable; fifo_read total is exactly 8.
   - Raise m_ready -> 3 beats in order: 0x04030201, 0x08070605, 0x0C0B0A09.
4. Partial flush: words 0xA1, 0xA2, 0xA3, then fifo_empty=1 and flush pulse.
   - Output 0x00A3A2A1, m_cnt=3, m_last=1.
   - flush_done pulses once, in the same cycle the beat loads.
5. Flush with a read in flight: flush asserted in the same cycle as the 2nd fifo_read.
   - No further reads; beat 0x0000B2B1 with m_cnt=2 and m_last=1.
6. Empty flush and reset mid-pack:
   - Flush with wc=0 -> no beat; flush_done one cycle after FLUSH_WAIT.
   - Reset after 2 words land, then feed 0xC1..0xC4 -> beat 0xC4C3C2C1 with no stale data.
